vga_timing_gen: RTL and testbench

Parametrised VGA timing generator, the successor to the fixed 640x480@60 controller. It produces the raw pixel counters used to address the image ROM, plus sync, data-enable and line/frame-start strobes. The strobes are delayed by a configurable number of cycles so they line up with a pixel pipeline of known latency. It sits between the pixel-clock source and the image/pixel path feeding the DAC.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/vga_timing_gen_delay_line.sv | 39 +++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets and the strobe bundle carried through the delay line.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, negative sync polarity
  localparam int unsigned Vga640HActive = 640;
  localparam int unsigned Vga640HFp     = 16;
  localparam int unsigned Vga640HSync   = 96;
  localparam int unsigned Vga640HBp     = 48;
  localparam int unsigned Vga640VActive = 480;
  localparam int unsigned Vga640VFp     = 10;
  localparam int unsigned Vga640VSync   = 2;
  localparam int unsigned Vga640VBp     = 33;
  localparam bit          Vga640HsPol   = 1'b0;
  localparam bit          Vga640VsPol   = 1'b0;

  // 800x600 @ 60 Hz, positive sync polarity
  localparam int unsigned Vga800HActive = 800;
  localparam int unsigned Vga800HFp     = 40;
  localparam int unsigned Vga800HSync   = 128;
  localparam int unsigned Vga800HBp     = 88;
  localparam int unsigned Vga800VActive = 600;
  localparam int unsigned Vga800VFp     = 1;
  localparam int unsigned Vga800VSync   = 4;
  localparam int unsigned Vga800VBp     = 23;
  localparam bit          Vga800HsPol   = 1'b1;
  localparam bit          Vga800VsPol   = 1'b1;

  // Strobes that travel together so they stay aligned with the pixel pipeline
  typedef struct packed {
    logic frame_start;
    logic line_start;
    logic data_enable;
    logic vs;
    logic hs;
  } strobe_t;

  localparam int unsigned StrobeW = $bits(strobe_t);

  // Inactive bundle: no pulses, no data, syncs at their idle level
  function automatic strobe_t strobe_idle(bit hs_pol, bit vs_pol);
    strobe_t s;
    s    = '0;
    s.hs = ~hs_pol;
    s.vs = ~vs_pol;
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous reset to RESET_VAL in every stage.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned        WIDTH     = StrobeW,
  parameter int unsigned        DEPTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Next state: new sample enters stage 0, everything else moves one stage on
  always_comb begin
    stage_d[0] = data_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raw pixel counters plus delayed sync/DE/start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIPE_DLY = 1,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] x_pixel,
  output logic [CNT_W-1:0] y_pixel,
  output logic             VGAHS,
  output logic             VGAVS,
  output logic             data_enable,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned HTotal   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned MaxTotal = (HTotal > VTotal) ? HTotal : VTotal;

  localparam logic [CNT_W-1:0] HLast      = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HActiveC   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActiveC   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam strobe_t StrobeIdle = strobe_idle(HS_POL, VS_POL);

  // Parameter sanity checks at elaboration
  if ((64'd1 << CNT_W) <= 64'(MaxTotal - 1)) begin : g_chk_cnt_w
    $error("CNT_W too narrow for max(H_TOTAL, V_TOTAL) - 1");
  end
  if (PIPE_DLY < 1) begin : g_chk_dly
    $error("PIPE_DLY must be at least 1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1)
  begin : g_chk_porch
    $error("porch and sync widths must be at least 1");
  end

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  strobe_t          strobe0;
  strobe_t          strobe_dly;

  // Raster counters: park at origin when disabled, wrap x then y at the totals
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!enable) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == HLast) begin
      x_d = '0;
      y_d = (y_q == VLast) ? '0 : y_q + CNT_W'(1);
    end else begin
      x_d = x_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Stage-0 strobes decoded from the current counters; forced idle while disabled
  always_comb begin
    strobe0 = StrobeIdle;
    if (enable) begin
      strobe0.data_enable = (x_q < HActiveC) && (y_q < VActiveC);
      strobe0.line_start  = (x_q == '0);
      strobe0.frame_start = (x_q == '0) && (y_q == '0);
      strobe0.hs = ((x_q >= HSyncStart) && (x_q < HSyncEnd)) ? HS_POL : ~HS_POL;
      strobe0.vs = ((y_q >= VSyncStart) && (y_q < VSyncEnd)) ? VS_POL : ~VS_POL;
    end
  end

  vga_delay_line #(
    .WIDTH    (StrobeW),
    .DEPTH    (PIPE_DLY),
    .RESET_VAL(StrobeIdle)
  ) u_delay_line (
    .clk_i (vga_clk),
    .rst_ni(rst_n),
    .data_i(strobe0),
    .data_o(strobe_dly)
  );

  assign x_pixel     = x_q;
  assign y_pixel     = y_q;
  assign VGAHS       = strobe_dly.hs;
  assign VGAVS       = strobe_dly.vs;
  assign data_enable = strobe_dly.data_enable;
  assign line_start  = strobe_dly.line_start;
  assign frame_start = strobe_dly.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four timing generators (two small rasters, 640x480, 800x600)
// checked against a cycle model whose delayed strobes flow through per-DUT queues.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int N = 4;
  localparam int unsigned HA [N] = '{8, 6, Vga640HActive, Vga800HActive};
  localparam int unsigned HF [N] = '{2, 1, Vga640HFp, Vga800HFp};
  localparam int unsigned HS [N] = '{3, 2, Vga640HSync, Vga800HSync};
  localparam int unsigned HB [N] = '{2, 3, Vga640HBp, Vga800HBp};
  localparam int unsigned VA [N] = '{4, 3, Vga640VActive, Vga800VActive};
  localparam int unsigned VF [N] = '{1, 2, Vga640VFp, Vga800VFp};
  localparam int unsigned VS [N] = '{2, 1, Vga640VSync, Vga800VSync};
  localparam int unsigned VB [N] = '{1, 2, Vga640VBp, Vga800VBp};
  localparam bit          HP [N] = '{1'b0, 1'b1, Vga640HsPol, Vga800HsPol};
  localparam bit          VP [N] = '{1'b0, 1'b1, Vga640VsPol, Vga800VsPol};
  localparam int unsigned DLY [N] = '{1, 3, 1, 1};

  logic        clk;
  logic        rst_n;
  logic        en   [N];
  logic [10:0] xs   [N];
  logic [10:0] ys   [N];
  logic        hs_o [N];
  logic        vs_o [N];
  logic        de_o [N];
  logic        ls_o [N];
  logic        fs_o [N];

  int          mx    [N];
  int          my    [N];
  logic [4:0]  exp_o [N];
  logic [4:0]  q0 [$];
  logic [4:0]  q1 [$];
  logic [4:0]  q2 [$];
  logic [4:0]  q3 [$];
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .HS_POL(HP[g]), .VS_POL(VP[g]), .PIPE_DLY(DLY[g]), .CNT_W(11)
    ) u_dut (
      .vga_clk    (clk),
      .rst_n      (rst_n),
      .enable     (en[g]),
      .x_pixel    (xs[g]),
      .y_pixel    (ys[g]),
      .VGAHS      (hs_o[g]),
      .VGAVS      (vs_o[g]),
      .data_enable(de_o[g]),
      .line_start (ls_o[g]),
      .frame_start(fs_o[g])
    );
  end

  function automatic int h_tot(int i);
    return int'(HA[i] + HF[i] + HS[i] + HB[i]);
  endfunction

  function automatic int v_tot(int i);
    return int'(VA[i] + VF[i] + VS[i] + VB[i]);
  endfunction

  // Strobe bits packed as {frame_start, line_start, data_enable, vs, hs}
  function automatic logic [4:0] obs(int i);
    return {fs_o[i], ls_o[i], de_o[i], vs_o[i], hs_o[i]};
  endfunction

  function automatic logic [4:0] idle(int i);
    return {3'b000, ~VP[i], ~HP[i]};
  endfunction

  function automatic logic [4:0] stage0(int i, logic e);
    logic [4:0] r;
    int hss;
    int vss;
    r   = idle(i);
    hss = int'(HA[i] + HF[i]);
    vss = int'(VA[i] + VF[i]);
    if (e) begin
      r[4] = (mx[i] == 0) && (my[i] == 0);
      r[3] = (mx[i] == 0);
      r[2] = (mx[i] < int'(HA[i])) && (my[i] < int'(VA[i]));
      if (my[i] >= vss && my[i] < vss + int'(VS[i])) r[1] = VP[i];
      if (mx[i] >= hss && mx[i] < hss + int'(HS[i])) r[0] = HP[i];
    end
    return r;
  endfunction

  task automatic sb_push(int i, logic [4:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic sb_pop(int i, output logic [4:0] v);
    case (i)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      2: v = q2.pop_front();
      default: v = q3.pop_front();
    endcase
  endtask

  // Hold reset, clear the model, release at a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    for (int i = 0; i < N; i++) begin
      mx[i]    = 0;
      my[i]    = 0;
      exp_o[i] = idle(i);
      for (int k = 1; k < int'(DLY[i]); k++) sb_push(i, idle(i));
    end
    rst_n = 1'b1;
  endtask

  // One clock: queue this cycle's stage-0 expectation, advance the model, sample at negedge
  task automatic tick();
    for (int i = 0; i < N; i++) sb_push(i, stage0(i, en[i]));
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!en[i]) begin
        mx[i] = 0;
        my[i] = 0;
      end else if (mx[i] == h_tot(i) - 1) begin
        mx[i] = 0;
        my[i] = (my[i] == v_tot(i) - 1) ? 0 : my[i] + 1;
      end else begin
        mx[i] = mx[i] + 1;
      end
      sb_pop(i, exp_o[i]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    #1 rst_n = 1'b0;
    #7;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (xs[i] !== 11'd0 || ys[i] !== 11'd0 || obs(i) !== idle(i)) begin
        n_errors++;
        $display("FAIL reset dut%0d: got x=%0d y=%0d strb=%b, want x=0 y=0 strb=%b",
                 i, xs[i], ys[i], obs(i), idle(i));
      end
    end
    do_reset();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (xs[i] !== 11'd0 || ys[i] !== 11'd0 || obs(i) !== idle(i)) begin
        n_errors++;
        $display("FAIL reset_release dut%0d: got x=%0d y=%0d strb=%b, want x=0 y=0 strb=%b",
                 i, xs[i], ys[i], obs(i), idle(i));
      end
    end
  endtask

  task automatic test_counting();
    int fs_t [N];
    int per  [N];
    for (int i = 0; i < N; i++) begin
      fs_t[i] = -1;
      per[i]  = -1;
    end
    for (int c = 0; c < 300; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (xs[i] !== 11'(mx[i]) || ys[i] !== 11'(my[i]) || obs(i) !== exp_o[i]) begin
          n_errors++;
          $display("FAIL sb_count dut%0d t=%0t: got x=%0d y=%0d strb=%b, want x=%0d y=%0d strb=%b",
                   i, $time, xs[i], ys[i], obs(i), mx[i], my[i], exp_o[i]);
        end
        if (fs_o[i] === 1'b1) begin
          if (fs_t[i] >= 0 && per[i] < 0) per[i] = c - fs_t[i];
          fs_t[i] = c;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (per[i] != h_tot(i) * v_tot(i)) begin
        n_errors++;
        $display("FAIL frame_period dut%0d: got %0d clocks, want %0d",
                 i, per[i], h_tot(i) * v_tot(i));
      end
    end
  endtask

  task automatic test_hsync();
    int   start_t [N];
    int   per     [N];
    int   run     [N];
    int   cur     [N];
    int   first_x [N];
    logic prev_a  [N];
    logic a;
    bit   found;
    for (int i = 0; i < N; i++) begin
      start_t[i] = -1;
      per[i]     = -1;
      run[i]     = -1;
      cur[i]     = 0;
      first_x[i] = -1;
      prev_a[i]  = 1'b0;
    end
    for (int c = 0; c < 2300; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (xs[i] !== 11'(mx[i]) || ys[i] !== 11'(my[i]) || obs(i) !== exp_o[i]) begin
          n_errors++;
          $display("FAIL sb_hsync dut%0d t=%0t: got x=%0d y=%0d strb=%b, want x=%0d y=%0d strb=%b",
                   i, $time, xs[i], ys[i], obs(i), mx[i], my[i], exp_o[i]);
        end
      end
      for (int i = 2; i < N; i++) begin
        a = (hs_o[i] === HP[i]);
        if (a && !prev_a[i]) begin
          if (start_t[i] >= 0 && per[i] < 0) per[i] = c - start_t[i];
          start_t[i] = c;
          if (first_x[i] < 0) first_x[i] = int'(xs[i]);
        end
        if (a) begin
          cur[i]++;
        end else if (prev_a[i]) begin
          if (run[i] < 0) run[i] = cur[i];
          cur[i] = 0;
        end
        prev_a[i] = a;
      end
    end
    for (int i = 2; i < N; i++) begin
      n_checks++;
      if (run[i] != int'(HS[i])) begin
        n_errors++;
        $display("FAIL hs_width dut%0d: got %0d clocks, want %0d", i, run[i], HS[i]);
      end
      n_checks++;
      if (per[i] != h_tot(i)) begin
        n_errors++;
        $display("FAIL hs_period dut%0d: got %0d clocks, want %0d", i, per[i], h_tot(i));
      end
      // Sync output lags the counter by one clock, so x has already moved one past the start
      n_checks++;
      if (first_x[i] != int'(HA[i] + HF[i]) + 1) begin
        n_errors++;
        $display("FAIL hs_start_x dut%0d: got x=%0d, want %0d",
                 i, first_x[i], HA[i] + HF[i] + 1);
      end
    end
    // Reset in the middle of a sync pulse must release the sync without a clock edge
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      tick();
      if (hs_o[2] === 1'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL hs_wait: got no sync pulse on dut2 within 1000 clocks, want one");
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (xs[i] !== 11'd0 || ys[i] !== 11'd0 || obs(i) !== idle(i)) begin
        n_errors++;
        $display("FAIL async_reset dut%0d: got x=%0d y=%0d strb=%b, want x=0 y=0 strb=%b",
                 i, xs[i], ys[i], obs(i), idle(i));
      end
    end
    do_reset();
  endtask

  task automatic test_vsync_de();
    int vs_cnt [2];
    int de_cnt [2];
    int vs_x;
    int vs_y;
    vs_x = -1;
    vs_y = -1;
    for (int i = 0; i < 2; i++) begin
      vs_cnt[i] = 0;
      de_cnt[i] = 0;
    end
    for (int c = 0; c < 120; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (xs[i] !== 11'(mx[i]) || ys[i] !== 11'(my[i]) || obs(i) !== exp_o[i]) begin
          n_errors++;
          $display("FAIL sb_vsync dut%0d t=%0t: got x=%0d y=%0d strb=%b, want x=%0d y=%0d strb=%b",
                   i, $time, xs[i], ys[i], obs(i), mx[i], my[i], exp_o[i]);
        end
      end
      if (vs_o[0] === 1'b0) begin
        if (vs_x < 0) begin
          vs_x = int'(xs[0]);
          vs_y = int'(ys[0]);
        end
        vs_cnt[0]++;
      end
      if (de_o[0] === 1'b1) de_cnt[0]++;
      if (c < 96) begin
        if (vs_o[1] === 1'b1) vs_cnt[1]++;
        if (de_o[1] === 1'b1) de_cnt[1]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (vs_cnt[i] != int'(VS[i]) * h_tot(i)) begin
        n_errors++;
        $display("FAIL vs_width dut%0d: got %0d clocks, want %0d",
                 i, vs_cnt[i], int'(VS[i]) * h_tot(i));
      end
      n_checks++;
      if (de_cnt[i] != int'(HA[i] * VA[i])) begin
        n_errors++;
        $display("FAIL de_per_frame dut%0d: got %0d clocks, want %0d",
                 i, de_cnt[i], HA[i] * VA[i]);
      end
    end
    n_checks++;
    if (vs_x != 1 || vs_y != int'(VA[0] + VF[0])) begin
      n_errors++;
      $display("FAIL vs_start dut0: got (%0d,%0d), want (1,%0d)", vs_x, vs_y, VA[0] + VF[0]);
    end
  endtask

  task automatic test_pipe3();
    int fs_lat;
    int de_lat;
    int ls_t;
    int ls_per;
    do_reset();
    fs_lat = -1;
    de_lat = -1;
    ls_t   = -1;
    ls_per = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (xs[i] !== 11'(mx[i]) || ys[i] !== 11'(my[i]) || obs(i) !== exp_o[i]) begin
          n_errors++;
          $display("FAIL sb_pipe3 dut%0d t=%0t: got x=%0d y=%0d strb=%b, want x=%0d y=%0d strb=%b",
                   i, $time, xs[i], ys[i], obs(i), mx[i], my[i], exp_o[i]);
        end
      end
      if (c < 12) begin
        n_checks++;
        if (xs[1] !== 11'(c)) begin
          n_errors++;
          $display("FAIL x_undelayed dut1: got x=%0d, want %0d", xs[1], c);
        end
      end
      if (fs_o[1] === 1'b1 && fs_lat < 0) fs_lat = c;
      if (de_o[1] === 1'b1 && de_lat < 0) de_lat = c;
      if (ls_o[1] === 1'b1) begin
        if (ls_t >= 0 && ls_per < 0) ls_per = c - ls_t;
        ls_t = c;
      end
    end
    n_checks++;
    if (fs_lat != 3) begin
      n_errors++;
      $display("FAIL fs_latency dut1: got %0d cycles, want 3", fs_lat);
    end
    n_checks++;
    if (de_lat != 3) begin
      n_errors++;
      $display("FAIL de_latency dut1: got %0d cycles, want 3", de_lat);
    end
    n_checks++;
    if (ls_per != 12) begin
      n_errors++;
      $display("FAIL ls_period dut1: got %0d clocks, want 12", ls_per);
    end
  endtask

  task automatic test_enable_drop();
    bit found;
    int lat [2];
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (mx[0] == 5 && my[0] == 2) found = 1'b1;
    end
    n_checks++;
    if (!found || xs[0] !== 11'd5 || ys[0] !== 11'd2) begin
      n_errors++;
      $display("FAIL drop_point dut0: got (%0d,%0d), want (5,2)", xs[0], ys[0]);
    end
    en[0] = 1'b0;
    en[1] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (xs[i] !== 11'(mx[i]) || ys[i] !== 11'(my[i]) || obs(i) !== exp_o[i]) begin
          n_errors++;
          $display("FAIL sb_drop dut%0d t=%0t: got x=%0d y=%0d strb=%b, want x=%0d y=%0d strb=%b",
                   i, $time, xs[i], ys[i], obs(i), mx[i], my[i], exp_o[i]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (xs[i] !== 11'd0 || ys[i] !== 11'd0) begin
          n_errors++;
          $display("FAIL drop_parked dut%0d: got (%0d,%0d), want (0,0)", i, xs[i], ys[i]);
        end
        if (c >= int'(DLY[i])) begin
          n_checks++;
          if (obs(i) !== idle(i)) begin
            n_errors++;
            $display("FAIL drop_idle dut%0d cyc%0d: got strb=%b, want %b",
                     i, c, obs(i), idle(i));
          end
        end
      end
    end
    en[0] = 1'b1;
    en[1] = 1'b1;
    lat[0] = -1;
    lat[1] = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (fs_o[i] === 1'b1 && lat[i] < 0) lat[i] = c;
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (lat[i] != int'(DLY[i])) begin
        n_errors++;
        $display("FAIL reenable_fs dut%0d: got %0d cycles, want %0d", i, lat[i], DLY[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_counting();
    test_hsync();
    test_vsync_de();
    test_pipe3();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
